load_store_unit: RTL and testbench

Data-side memory initiator for the CPU core. Accepts load/store requests with byte addresses from the execute stage and drives the word-addressed, single-port synchronous data memory port (rw/ain/din/dout). Performs byte/half/word extraction with sign or zero extension on loads, and read-modify-write merging on sub-word stores because the memory has no byte enables. One request is in flight at a time; each produces exactly one single-cycle response pulse.

---
 rtl/load_store_unit.sv | 205 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
// Data-side memory initiator for the CPU core. It takes byte-addressed
// load/store requests and drives a word-addressed, single-port synchronous
// data memory. Loads return a byte, half or word that is sign- or zero-extended.
// The memory has no byte enables, so sub-word stores are done as a
// read-modify-write. Only one request is in flight at a time, and each request
// produces exactly one single-cycle response pulse.
//
// Ports
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   req_valid/ready     request handshake (accepted on valid & ready)
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10/11 word
//   req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   req_addr/wdata      byte address; right-aligned store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata/err      extended load data (0 for stores); misalignment flag
//   mem_rw/ain/din      memory write enable, word address, write data
//   mem_dout            memory read data, valid the cycle after ain is sampled
//
// Build option
//   LSU_MISALIGN_TRAP_EN  when defined, a misaligned half or word access
//                         returns resp_err=1 and does not touch memory. When
//                         undefined, the offending low address bits are
//                         ignored and resp_err stays 0.

module load_store_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rw,
  output logic [31:0] mem_ain,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR, RESP} state_t;

  state_t      state, state_next;

  // Request fields captured at acceptance
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_offset;
  logic [31:0] lat_wdata;

  logic        rw_next;
  logic [31:0] ain_next;
  logic [31:0] din_next;
  logic        valid_next;
  logic [31:0] rdata_next;
  logic        err_next;

  // Byte offset of the addressed lane. A half access uses only addr[1] and a
  // word access always uses offset 0, so the misaligned low bits are dropped.
  function automatic logic [1:0] lane_offset(input logic [1:0] size,
                                             input logic [1:0] low);
    case (size)
      2'b00:   return low;
      2'b01:   return {low[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  offset,
                                               input logic [1:0]  size,
                                               input logic        zero_ext);
    logic [31:0] shifted;
    logic [31:0] ext;
    shifted = word >> {offset, 3'b000};
    case (size)
      2'b00: begin
        if (zero_ext) ext = {24'h0, shifted[7:0]};
        else          ext = {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        if (zero_ext) ext = {16'h0, shifted[15:0]};
        else          ext = {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ext = shifted;
    endcase
    return ext;
  endfunction

  // Replaces only the addressed byte or half. Every other byte of the old
  // word is kept unchanged.
  function automatic logic [31:0] merge_store(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  offset,
                                              input logic [1:0]  size);
    logic [31:0] mask;
    mask = (size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    mask = mask << {offset, 3'b000};
    return (old & ~mask) | ((wdata << {offset, 3'b000}) & mask);
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] low);
    return ((size == 2'b01) && low[0]) || (size[1] && (low != 2'b00));
  endfunction
`endif

  assign req_ready = (state == IDLE) && !reset;

  always_comb begin
    state_next = state;
    rw_next    = 1'b0;
    ain_next   = mem_ain;
    din_next   = mem_din;
    valid_next = 1'b0;
    rdata_next = resp_rdata;
    err_next   = resp_err;
    case (state)
      // Accept: a word store goes straight to WR; every other access reads first
      IDLE: begin
        if (req_valid) begin
          ain_next = {2'b00, req_addr[31:2]};
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned(req_size, req_addr[1:0])) begin
            state_next = RESP;
            ain_next   = mem_ain;
            valid_next = 1'b1;
            rdata_next = 32'h0;
            err_next   = 1'b1;
          end else
`endif
          if (req_we && req_size[1]) begin
            state_next = WR;
            rw_next    = 1'b1;
            din_next   = req_wdata;
          end else begin
            state_next = RD_REQ;
          end
        end
      end
      // Memory samples ain at the end of this cycle
      RD_REQ: state_next = RD_DATA;
      // mem_dout is valid here: either merge it for a store or extract it for a load
      RD_DATA: begin
        if (lat_we) begin
          state_next = WR;
          rw_next    = 1'b1;
          din_next   = merge_store(mem_dout, lat_wdata, lat_offset, lat_size);
        end else begin
          state_next = RESP;
          valid_next = 1'b1;
          rdata_next = extract_load(mem_dout, lat_offset, lat_size, lat_unsigned);
          err_next   = 1'b0;
        end
      end
      // Write commits at the edge that ends this cycle
      WR: begin
        state_next = RESP;
        valid_next = 1'b1;
        rdata_next = 32'h0;
        err_next   = 1'b0;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_rw     <= 1'b0;
      mem_ain    <= 32'h0;
      mem_din    <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_next;
      mem_rw     <= rw_next;
      mem_ain    <= ain_next;
      mem_din    <= din_next;
      resp_valid <= valid_next;
      resp_rdata <= rdata_next;
      resp_err   <= err_next;
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && req_valid) begin
      lat_we       <= req_we;
      lat_size     <= req_size;
      lat_unsigned <= req_unsigned;
      lat_offset   <= lane_offset(req_size, req_addr[1:0]);
      lat_wdata    <= req_wdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit. The bench includes a behavioural
// single-port synchronous memory that reads one cycle after ain is sampled.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rw;
  logic [31:0] mem_ain;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:63] = '{default: 32'h0};

  int pass_cnt = 0;
  int chk_cnt  = 0;

  load_store_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rw(mem_rw), .mem_ain(mem_ain), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_rw) mem[mem_ain[5:0]] <= mem_din;
    mem_dout <= mem[mem_ain[5:0]];
  end

  // Issues one request, then scrambles the inputs. For the 8 cycles after
  // acceptance it records the response latency, the first response, the number
  // of cycles with mem_rw high, the number of cycles with resp_valid high, and
  // the number of busy cycles in which req_ready was high.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int rwc, output int pl, output int rdy);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!req_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_we = ~we; req_size = 2'b00; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFC; req_wdata = 32'hA5A5_A5A5;
    lat = -1; rd = 32'hx; er = 1'bx; rwc = 0; pl = 0; rdy = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (mem_rw) rwc++;
      if (lat < 0 && req_ready) rdy++;
      if (resp_valid) begin
        pl++;
        if (lat < 0) begin
          lat = c; rd = resp_rdata; er = resp_err;
        end
      end
    end
  endtask

  task automatic test_reset;
    @(posedge clock);
    #1;
    chk_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", req_ready); else pass_cnt++;
    chk_cnt++; if ({mem_rw, resp_valid, resp_err} !== 3'b000) $display("FAIL rst_ctrl: got %b expected 000", {mem_rw, resp_valid, resp_err}); else pass_cnt++;
    chk_cnt++; if ({mem_ain, mem_din, resp_rdata} !== 96'h0) $display("FAIL rst_data: got %h expected 0", {mem_ain, mem_din, resp_rdata}); else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", req_ready); else pass_cnt++;
  endtask

  task automatic test_word_store_load;
    int lat, rwc, pl, rdy; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, er, rwc, pl, rdy);
    chk_cnt++; if (lat !== 2) $display("FAIL wst_latency: got %0d expected 2", lat); else pass_cnt++;
    chk_cnt++; if (rwc !== 1) $display("FAIL wst_rw_cycles: got %0d expected 1", rwc); else pass_cnt++;
    chk_cnt++; if (pl !== 1) $display("FAIL wst_pulse: got %0d expected 1", pl); else pass_cnt++;
    chk_cnt++; if (rdy !== 0) $display("FAIL wst_busy_ready: got %0d expected 0", rdy); else pass_cnt++;
    chk_cnt++; if (mem[4] !== 32'hDEAD_BEEF) $display("FAIL wst_mem: got %h expected deadbeef", mem[4]); else pass_cnt++;
    chk_cnt++; if ({er, rd} !== 33'h0) $display("FAIL wst_resp: got %h expected 0", {er, rd}); else pass_cnt++;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, rwc, pl, rdy);
    chk_cnt++; if (lat !== 3) $display("FAIL wld_latency: got %0d expected 3", lat); else pass_cnt++;
    chk_cnt++; if (rd !== 32'hDEAD_BEEF) $display("FAIL wld_data: got %h expected deadbeef", rd); else pass_cnt++;
    chk_cnt++; if (rwc !== 0) $display("FAIL wld_rw_cycles: got %0d expected 0", rwc); else pass_cnt++;
    chk_cnt++; if (pl !== 1) $display("FAIL wld_pulse: got %0d expected 1", pl); else pass_cnt++;
  endtask

  task automatic test_byte_load;
    int lat, rwc, pl, rdy; logic [31:0] rd; logic er;
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er, rwc, pl, rdy);
    chk_cnt++; if (rd !== 32'hFFFF_FFDE) $display("FAIL lb_13_signed: got %h expected ffffffde", rd); else pass_cnt++;
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, er, rwc, pl, rdy);
    chk_cnt++; if (rd !== 32'h0000_00DE) $display("FAIL lb_13_unsigned: got %h expected 000000de", rd); else pass_cnt++;
    do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, rd, er, rwc, pl, rdy);
    chk_cnt++; if (rd !== 32'hFFFF_FFEF) $display("FAIL lb_10_signed: got %h expected ffffffef", rd); else pass_cnt++;
  endtask

  task automatic test_byte_store;
    int lat, rwc, pl, rdy; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FF55, lat, rd, er, rwc, pl, rdy);
    chk_cnt++; if (lat !== 4) $display("FAIL sb_latency: got %0d expected 4", lat); else pass_cnt++;
    chk_cnt++; if (rwc !== 1) $display("FAIL sb_rw_cycles: got %0d expected 1", rwc); else pass_cnt++;
    chk_cnt++; if (mem[4] !== 32'hDEAD_55EF) $display("FAIL sb_mem: got %h expected dead55ef", mem[4]); else pass_cnt++;
    chk_cnt++; if (rd !== 32'h0) $display("FAIL sb_rdata: got %h expected 0", rd); else pass_cnt++;
  endtask

  task automatic test_half;
    int lat, rwc, pl, rdy; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hAAAA_1234, lat, rd, er, rwc, pl, rdy);
    chk_cnt++; if (lat !== 4) $display("FAIL sh_latency: got %0d expected 4", lat); else pass_cnt++;
    chk_cnt++; if (mem[4] !== 32'h1234_55EF) $display("FAIL sh_mem: got %h expected 123455ef", mem[4]); else pass_cnt++;
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, er, rwc, pl, rdy);
    chk_cnt++; if (rd !== 32'h0000_1234) $display("FAIL lh_12_signed: got %h expected 00001234", rd); else pass_cnt++;
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, rd, er, rwc, pl, rdy);
    chk_cnt++; if (rd !== 32'h0000_55EF) $display("FAIL lh_10_signed: got %h expected 000055ef", rd); else pass_cnt++;
    do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, lat, rd, er, rwc, pl, rdy);
    chk_cnt++; if (rd !== 32'h0000_0034) $display("FAIL lb_12_signed: got %h expected 00000034", rd); else pass_cnt++;
  endtask

  task automatic test_misaligned;
    int lat, rwc, pl, rdy; logic [31:0] rd; logic er;
    do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, lat, rd, er, rwc, pl, rdy);
`ifdef LSU_MISALIGN_TRAP_EN
    chk_cnt++; if (lat !== 1) $display("FAIL mis_latency: got %0d expected 1", lat); else pass_cnt++;
    chk_cnt++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL mis_resp: got %h expected 100000000", {er, rd}); else pass_cnt++;
`else
    chk_cnt++; if (lat !== 3) $display("FAIL mis_latency: got %0d expected 3", lat); else pass_cnt++;
    chk_cnt++; if ({er, rd} !== {1'b0, 32'h1234_55EF}) $display("FAIL mis_resp: got %h expected 0123455ef", {er, rd}); else pass_cnt++;
`endif
    chk_cnt++; if (rwc !== 0) $display("FAIL mis_rw_cycles: got %0d expected 0", rwc); else pass_cnt++;
    do_req(1'b0, 2'b11, 1'b1, 32'h10, 32'h0, lat, rd, er, rwc, pl, rdy);
    chk_cnt++; if (rd !== 32'h1234_55EF) $display("FAIL reserved_size: got %h expected 123455ef", rd); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int lat, rwc, pl, rdy; logic [31:0] rd; logic er;
    int pulses;
    pulses = 0;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    chk_cnt++; if (mem_rw !== 1'b1) $display("FAIL rmid_rw_before: got %b expected 1", mem_rw); else pass_cnt++;
    reset = 1'b1;
    #1;
    chk_cnt++; if (mem_rw !== 1'b0) $display("FAIL rmid_rw_drop: got %b expected 0", mem_rw); else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      if (resp_valid) pulses++;
    end
    reset = 1'b0;
    #1;
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL rmid_ready: got %b expected 1", req_ready); else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (resp_valid) pulses++;
    end
    chk_cnt++; if (pulses !== 0) $display("FAIL rmid_no_resp: got %0d expected 0", pulses); else pass_cnt++;
    chk_cnt++; if (mem[8] !== 32'h0) $display("FAIL rmid_mem: got %h expected 0", mem[8]); else pass_cnt++;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er, rwc, pl, rdy);
    chk_cnt++; if (lat !== 3 || rd !== 32'h0) $display("FAIL rmid_reload: got lat %0d data %h expected lat 3 data 0", lat, rd); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_word_store_load;
    test_byte_load;
    test_byte_store;
    test_half;
    test_misaligned;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
